// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the framed configuration loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_CRC     = 2'd3;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // One serial CRC-8 step: shift left, fold in the polynomial when the feedback bit is set.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic bit_i);
    crc8_bit = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_i) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lanes.sv
// Combinational CRC-8 update over one LANES-bit beat, MSB first.
module crc8_lanes
  import cfg_loader_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic [7:0]       crc_in,
  input  logic [LANES-1:0] data,
  output logic [7:0]       crc_out
);

  logic [LANES-1:0] data_sh;

  // Walk the beat from its top bit down, one serial step per lane.
  always_comb begin
    crc_out = crc_in;
    data_sh = data;
    for (int unsigned i = 0; i < LANES; i++) begin
      crc_out = crc8_bit(crc_out, data_sh[LANES-1]);
      data_sh = data_sh << 1;
    end
  end

endmodule

// File: rtl/cfg_stream_loader.sv
// Framed multi-lane configuration loader: shifts beats into a shadow register,
// checks frame length and CRC-8, and commits to cfg_out only on a good frame.
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CFG_SIZE = 100,
  parameter int unsigned LANES    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stream_valid,
  output logic                stream_ready,
  input  logic [LANES-1:0]    stream_data,
  input  logic                stream_last,
  input  logic [7:0]          stream_crc,
  input  logic                err_clr,
  output logic [CFG_SIZE-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [1:0]          err_code
);

  localparam int unsigned BEATS = CFG_SIZE / LANES;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  // Reject illegal geometries at elaboration.
  generate
    if ((LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) ||
        CFG_SIZE == 0 || (CFG_SIZE % LANES) != 0) begin : g_param_chk
      $error("cfg_stream_loader: CFG_SIZE must be a non-zero multiple of LANES, LANES in {1,2,4,8}");
    end
  endgenerate

  state_e              state_q;
  logic [CFG_SIZE-1:0] shadow_q;
  logic [CFG_SIZE-1:0] shadow_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [7:0]          crc_q;
  logic [7:0]          crc_d;
  logic [CFG_SIZE-1:0] cfg_out_q;
  logic                cfg_valid_q;
  logic                cfg_done_q;
  logic                cfg_err_q;
  logic [1:0]          err_code_q;

  logic beat_acc;
  logic frame_full;

  // Shadow shift: the newest beat lands in the low bits.
  generate
    if (CFG_SIZE == LANES) begin : g_shadow_one
      assign shadow_d = stream_data;
    end else begin : g_shadow_shift
      assign shadow_d = {shadow_q[CFG_SIZE-LANES-1:0], stream_data};
    end
  endgenerate

  crc8_lanes #(
    .LANES (LANES)
  ) u_crc (
    .crc_in  (crc_q),
    .data    (stream_data),
    .crc_out (crc_d)
  );

  assign stream_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign beat_acc     = stream_valid && stream_ready;
  assign count_d      = count_q + CNT_W'(1);
  assign frame_full   = (count_q == LAST_IDX);

  // Loader FSM with registered outputs; frame outcome decided on the ending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      count_q     <= '0;
      crc_q       <= CRC8_INIT;
      cfg_out_q   <= '0;
      cfg_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      cfg_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (beat_acc) begin
            shadow_q <= shadow_d;
            crc_q    <= crc_d;
            count_q  <= count_d;
            if (stream_last && !frame_full) begin
              state_q    <= ST_ERR;
              cfg_err_q  <= 1'b1;
              err_code_q <= ERR_SHORT;
            end else if (!stream_last && frame_full) begin
              state_q    <= ST_ERR;
              cfg_err_q  <= 1'b1;
              err_code_q <= ERR_OVERRUN;
            end else if (stream_last) begin
              if (crc_d != stream_crc) begin
                state_q    <= ST_ERR;
                cfg_err_q  <= 1'b1;
                err_code_q <= ERR_CRC;
              end else begin
                state_q <= ST_COMMIT;
              end
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_COMMIT: begin
          cfg_out_q   <= shadow_q;
          cfg_valid_q <= 1'b1;
          cfg_done_q  <= 1'b1;
          count_q     <= '0;
          crc_q       <= CRC8_INIT;
          state_q     <= ST_IDLE;
        end
        ST_ERR: begin
          if (err_clr) begin
            state_q    <= ST_IDLE;
            cfg_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
            crc_q      <= CRC8_INIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_out   = cfg_out_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign err_code  = err_code_q;

endmodule
